// File: rtl/aipp_temporal_token_issuer_if.sv
// Request/token bundle between the dispatcher/switch side and the temporal token issuer.
interface aipp_temporal_token_issuer_if;
   localparam int unsigned TOKEN_W  = 128;
   localparam int unsigned CREDIT_W = 4;
   localparam int unsigned SEQ_W    = 16;

   logic                req_valid;
   logic                req_ready;
   logic                revoke;
   logic [TOKEN_W-1:0]  token_out;
   logic                token_active;
   logic [CREDIT_W-1:0] credits;
   logic [SEQ_W-1:0]    seq_num;
   logic                expired_pulse;
   logic                revoked_pulse;

   modport master (
      output req_valid, revoke,
      input  req_ready, token_out, token_active, credits, seq_num,
             expired_pulse, revoked_pulse
   );

   modport slave (
      input  req_valid, revoke,
      output req_ready, token_out, token_active, credits, seq_num,
             expired_pulse, revoked_pulse
   );
endinterface

// File: rtl/aipp_temporal_token_issuer.sv
// Credit-metered issuer of the 128-bit temporal token: grant window, forced-zero cooldown,
// and a refilling power-credit bucket.
module aipp_temporal_token_issuer #(
   parameter int unsigned WINDOW_CYCLES   = 64,
   parameter int unsigned COOLDOWN_CYCLES = 16,
   parameter int unsigned CREDIT_MAX      = 8,
   parameter int unsigned REFILL_PERIOD   = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   aipp_temporal_token_issuer_if.slave  bus
);
   localparam int unsigned TS_W    = 32;
   localparam int unsigned SEQ_W   = 16;
   localparam int unsigned CRED_W  = 4;
   localparam int unsigned TOKEN_W = 128;
   localparam int unsigned CNT_MAX = (WINDOW_CYCLES > COOLDOWN_CYCLES) ? WINDOW_CYCLES : COOLDOWN_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned REF_W   = $clog2(REFILL_PERIOD);
   localparam logic [15:0] MAGIC   = 16'hA11D;

   typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN} state_t;

   state_t             state_q;
   logic [TS_W-1:0]    ts_q;
   logic [REF_W-1:0]   refill_q;
   logic [CRED_W-1:0]  credits_q;
   logic [CRED_W-1:0]  credits_d;
   logic [SEQ_W-1:0]   seq_q;
   logic [SEQ_W-1:0]   seq_inc;
   logic [CNT_W-1:0]   cnt_q;
   logic [TOKEN_W-1:0] token_q;
   logic [TOKEN_W-1:0] token_d;
   logic [TS_W-1:0]    expiry;
   logic               active_q;
   logic               expired_q;
   logic               revoked_q;
   logic               req_ready_c;
   logic               handshake;
   logic               refill_wrap;
   logic               hold_exit;

   // Readiness depends on registered state plus the live revoke input.
   assign req_ready_c = (state_q == IDLE) && (credits_q != '0) && !bus.revoke;
   assign handshake   = bus.req_valid && req_ready_c;
   assign refill_wrap = (refill_q == REF_W'(REFILL_PERIOD - 1));
   assign hold_exit   = bus.revoke || !bus.req_valid || (cnt_q == CNT_W'(WINDOW_CYCLES - 1));
   assign seq_inc     = seq_q + SEQ_W'(1);
   assign expiry      = ts_q + TS_W'(WINDOW_CYCLES);
   assign token_d     = {28'd0, credits_d, ts_q, expiry, seq_inc, MAGIC};

   // A handshake and a refill in the same cycle cancel out.
   always_comb begin
      credits_d = credits_q;
      if (handshake && !refill_wrap) begin
         credits_d = credits_q - CRED_W'(1);
      end else if (refill_wrap && !handshake && (credits_q != CRED_W'(CREDIT_MAX))) begin
         credits_d = credits_q + CRED_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ts_q      <= '0;
         refill_q  <= '0;
         credits_q <= CRED_W'(CREDIT_MAX);
         seq_q     <= '0;
         cnt_q     <= '0;
         token_q   <= '0;
         active_q  <= 1'b0;
         expired_q <= 1'b0;
         revoked_q <= 1'b0;
      end else begin
         ts_q      <= ts_q + TS_W'(1);
         refill_q  <= refill_wrap ? '0 : refill_q + REF_W'(1);
         credits_q <= credits_d;
         expired_q <= 1'b0;
         revoked_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (handshake) begin
                  state_q  <= HOLD;
                  seq_q    <= seq_inc;
                  token_q  <= token_d;
                  active_q <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_exit) begin
                  // Priority revoke > release > timeout; only timeout or revoke pulse.
                  state_q   <= COOLDOWN;
                  cnt_q     <= '0;
                  token_q   <= '0;
                  active_q  <= 1'b0;
                  revoked_q <= bus.revoke;
                  expired_q <= !bus.revoke && bus.req_valid;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            COOLDOWN: begin
               if (cnt_q == CNT_W'(COOLDOWN_CYCLES - 1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               token_q  <= '0;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.token_out     = token_q;
   assign bus.token_active  = active_q;
   assign bus.credits       = credits_q;
   assign bus.seq_num       = seq_q;
   assign bus.expired_pulse = expired_q;
   assign bus.revoked_pulse = revoked_q;
endmodule
